gcd_multi: RTL and testbench
============================

# gcd_multi

Parametrised N-operand greatest-common-divisor engine; next generation of the fixed three-input 16-bit `gcd_top`. It folds `N` operands of `WIDTH` bits pairwise through an iterative binary (Stein) GCD core, one reduction step per cycle. It adds three behaviours: defined zero-operand results, abort-and-restart when `start` arrives mid-computation, and a `busy` status output. It sits on the same start/valid handshake as its predecessor.

## Interface
- `WIDTH`, 16, operand and result width in bits (≥2)
- `N`, 3, number of operands (≥2)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; operands captured on the same edge
- `ops`  in  N*WIDTH  packed operands; operand i = `ops[i*WIDTH +: WIDTH]`
- `D`  out  WIDTH  GCD of all N operands; valid while `valid`=1
- `valid`  out  1  result ready; held until next `start` or reset
- `busy`  out  1  computation in progress

## Operation
- States: IDLE, LOAD, REDUCE, DONE.
- On `start` (any state): capture `ops` into an internal operand register and set `acc`=op0, `idx`=1. Clear `valid`, set `busy`, go to LOAD.
  - `ops` is don't-care after the capture edge.
- LOAD: `a`=`acc`, `b`=op[idx], `k`=0.
  - If `a`=0, pair result = `b`.
  - Else if `b`=0, pair result = `a`.
  - In both zero cases, skip REDUCE and go to pair completion. Otherwise go to REDUCE.
- REDUCE, one step per cycle, first matching rule applies:
  - `a`==`b`: pair result = `a`<<`k`; pair completes.
  - `a` and `b` both even: `a`>>=1, `b`>>=1, `k`+=1.
  - `a` even only: `a`>>=1.
  - `b` even only: `b`>>=1.
  - `a`>`b`: `a`=(`a`-`b`)>>1.
  - Otherwise: `b`=(`b`-`a`)>>1.
- Pair completion: `acc` = pair result.
  - If `idx`=N-1, go to DONE.
  - Else `idx`+=1 and go to LOAD.
- DONE: `D`=`acc`, `valid`=1, `busy`=0, return to IDLE.
  - `D` and `valid` hold in IDLE.
- Arithmetic widths:
  - `a`, `b`, `acc`: WIDTH bits.
  - `k`: clog2(WIDTH)+1 bits.
  - Subtraction never underflows (guarded by the compare).
  - `a`<<`k` never exceeds WIDTH bits, because it equals a divisor of a WIDTH-bit value.
- gcd(0,x)=x; all-zero operands give `D`=0 with `valid`=1.
- `start` while `busy`: the current computation is discarded and no `valid` pulse is produced for it. The new computation starts from LOAD.
- `start` on the cycle `valid`=1: `valid` drops on that edge and the new computation proceeds.

## Timing
- Reset (asynchronous assert, synchronous-clean deassert): `D`=0, `valid`=0, `busy`=0, state IDLE.
  - Reset asserted mid-operation kills the computation immediately.
  - No `valid` appears after release until a new `start`.
- Edge numbering: `start` sampled at edge 0. `busy`=1 and `valid`=0 from edge 0.
- Latency:
  - Per pair: 1 LOAD cycle plus at most 2*WIDTH+1 REDUCE cycles (each step removes ≥1 bit from `a`+`b`).
  - `valid` rises no earlier than edge 3.
  - `valid` rises no later than edge (N-1)*(2*WIDTH+2)+2.
  - Never in the same cycle as `start`.
- `busy` and `valid` are never both 1.

## Test plan
- Basic: WIDTH=16, N=3, ops=16,8,4 -> `D`=4 and `valid`=1 within the latency bound. `valid` must be 0 at edges 0–2.
- Coprime: ops=3571,2711,1543 -> `D`=1. `valid` held high for ≥5 idle cycles with `D` stable.
- Zeros:
  - ops=0,0,12 -> `D`=12.
  - ops=0,0,0 -> `D`=0.
  - ops=48,0,36 -> `D`=12.
- Restart:
  - Start ops=3571,2711,1543, then assert `start` with ops=48,36,60 five cycles later.
  - Exactly one `valid` rising edge follows, with `D`=12.
- Reset mid-op: pull `reset` low between clock edges during REDUCE.
  - `busy`, `valid` and `D` go to 0 before the next edge.
  - After release, `valid` stays 0 for 20 cycles with no `start`.
- Parameter sweep:
  - WIDTH=32, N=4, ops=0xFFFFFFFE,0x80000000,6,10 -> `D`=2.
  - WIDTH=16, N=3, ops=65535,65535,65535 -> `D`=65535.
  - Both within the latency bound.

Source files
------------

// File: rtl/gcd_multi.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_multi
//  Purpose  : N-operand greatest-common-divisor engine. Operands are folded
//             pairwise into an accumulator through an iterative binary (Stein)
//             GCD core that performs one reduction step per clock. Supports
//             zero operands, abort-and-restart on start, and a busy flag.
//  Revision : 1.0 - initial release
// ============================================================================
module gcd_multi #(
    parameter int WIDTH = 16,
    parameter int N     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N*WIDTH-1:0] ops,
    output logic [WIDTH-1:0]   D,
    output logic               valid,
    output logic               busy
);

    // Width of the operand index and of the common power-of-two counter
    localparam int IDX_W = $clog2(N);
    localparam int K_W   = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_REDUCE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q;
    logic [N*WIDTH-1:0] ops_q;
    logic [WIDTH-1:0]   acc_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [K_W-1:0]     k_q;
    logic [WIDTH-1:0]   d_q;
    logic               valid_q;
    logic               busy_q;

    logic [WIDTH-1:0]   op_cur;
    logic               pair_done;
    logic [WIDTH-1:0]   acc_d;

    // Select the operand currently being folded into the accumulator
    always_comb begin
        op_cur = ops_q[idx_q*WIDTH +: WIDTH];
    end

    // Detect completion of the current pair and compute its result
    always_comb begin
        pair_done = 1'b0;
        acc_d     = acc_q;
        case (state_q)
            S_LOAD: begin
                // gcd(0,x)=x: a zero on either side finishes the pair at once
                if (acc_q == '0) begin
                    pair_done = 1'b1;
                    acc_d     = op_cur;
                end else if (op_cur == '0) begin
                    pair_done = 1'b1;
                    acc_d     = acc_q;
                end
            end
            S_REDUCE: begin
                // Restore the common factor of two stripped during reduction
                if (a_q == b_q) begin
                    pair_done = 1'b1;
                    acc_d     = a_q << k_q;
                end
            end
            default: begin
                pair_done = 1'b0;
                acc_d     = acc_q;
            end
        endcase
    end

    // Control FSM and datapath; start takes priority in every state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ops_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            d_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (start) begin
            ops_q   <= ops;
            acc_q   <= ops[WIDTH-1:0];
            idx_q   <= IDX_W'(1);
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_IDLE;
                end
                S_LOAD: begin
                    a_q     <= acc_q;
                    b_q     <= op_cur;
                    k_q     <= '0;
                    state_q <= S_REDUCE;
                end
                S_REDUCE: begin
                    if (a_q != b_q) begin
                        if (!a_q[0] && !b_q[0]) begin
                            a_q <= a_q >> 1;
                            b_q <= b_q >> 1;
                            k_q <= k_q + 1'b1;
                        end else if (!a_q[0]) begin
                            a_q <= a_q >> 1;
                        end else if (!b_q[0]) begin
                            b_q <= b_q >> 1;
                        end else if (a_q > b_q) begin
                            a_q <= (a_q - b_q) >> 1;
                        end else begin
                            b_q <= (b_q - a_q) >> 1;
                        end
                    end
                end
                S_DONE: begin
                    d_q     <= acc_q;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Pair completion overrides the state chosen above
            if (pair_done) begin
                acc_q <= acc_d;
                if (idx_q == IDX_W'(N - 1)) begin
                    state_q <= S_DONE;
                end else begin
                    idx_q   <= idx_q + 1'b1;
                    state_q <= S_LOAD;
                end
            end
        end
    end

    assign D     = d_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcd_multi
//  Purpose  : Self-checking bench for gcd_multi. Two instances (16-bit/3-op
//             and 32-bit/4-op) are compared against a Euclid-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_multi;

    logic         clk = 1'b0;
    logic         reset = 1'b0;

    logic         start16 = 1'b0;
    logic [47:0]  ops16 = '0;
    logic [15:0]  d16;
    logic         valid16;
    logic         busy16;

    logic         start32 = 1'b0;
    logic [127:0] ops32 = '0;
    logic [31:0]  d32;
    logic         valid32;
    logic         busy32;

    int checks = 0;
    int errors = 0;

    localparam int BOUND16 = 2 * (2 * 16 + 2) + 2;
    localparam int BOUND32 = 3 * (2 * 32 + 2) + 2;

    always #5 clk = ~clk;

    gcd_multi #(.WIDTH(16), .N(3)) dut16 (
        .clk   (clk),
        .reset (reset),
        .start (start16),
        .ops   (ops16),
        .D     (d16),
        .valid (valid16),
        .busy  (busy16)
    );

    gcd_multi #(.WIDTH(32), .N(4)) dut32 (
        .clk   (clk),
        .reset (reset),
        .start (start32),
        .ops   (ops32),
        .D     (d32),
        .valid (valid32),
        .busy  (busy32)
    );

    // busy and valid must never be high together
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if ((busy16 && valid16) || (busy32 && valid32)) begin
                errors++;
                $display("FAIL busy_valid_excl: busy16=%0b valid16=%0b busy32=%0b valid32=%0b required not both 1",
                         busy16, valid16, busy32, valid32);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic longint unsigned gcd2(input longint unsigned a, input longint unsigned b);
        longint unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic longint unsigned model(input bit wide, input logic [127:0] o);
        longint unsigned acc = 0;
        int n = wide ? 4 : 3;
        int w = wide ? 32 : 16;
        for (int i = 0; i < n; i++) begin
            longint unsigned v = wide ? longint'(o[i*32 +: 32]) : longint'(o[i*16 +: 16]);
            if (w == 16) v = v & 64'hFFFF;
            acc = gcd2(acc, v);
        end
        return acc;
    endfunction

    function automatic logic [127:0] pack16(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
        return {80'b0, a2, a1, a0};
    endfunction

    function automatic logic [127:0] pack32(input logic [31:0] a0, input logic [31:0] a1,
                                            input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Present operands for one cycle; returns at the negedge after capture edge 0
    task automatic launch(input bit wide, input logic [127:0] o);
        @(negedge clk);
        if (wide) begin
            ops32   = o;
            start32 = 1'b1;
        end else begin
            ops16   = o[47:0];
            start16 = 1'b1;
        end
        @(negedge clk);
        start16 = 1'b0;
        start32 = 1'b0;
        ops16   = {$urandom, $urandom};
        ops32   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Count edges after edge 0 until valid is seen (or the limit expires)
    task automatic wait_valid(input bit wide, output int edges, output bit seen);
        edges = 0;
        while (!(wide ? valid32 : valid16) && edges < 400) begin
            @(negedge clk);
            edges++;
        end
        seen = wide ? valid32 : valid16;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #1;
        checks++;
        if (d16 !== 16'd0 || valid16 !== 1'b0 || busy16 !== 1'b0 ||
            d32 !== 32'd0 || valid32 !== 1'b0 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: D16=%0d v16=%0b b16=%0b D32=%0d v32=%0b b32=%0b required all 0",
                     d16, valid16, busy16, d32, valid32, busy32);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int e; bit s;
        launch(1'b0, pack16(16, 8, 4));
        checks++;
        if (busy16 !== 1'b1 || valid16 !== 1'b0) begin
            errors++;
            $display("FAIL basic_edge0: busy=%0b valid=%0b required busy=1 valid=0", busy16, valid16);
        end
        wait_valid(1'b0, e, s);
        checks++;
        if (!s || d16 !== 16'd4) begin
            errors++;
            $display("FAIL basic_result: valid=%0b D=%0d required valid=1 D=4", s, d16);
        end
        checks++;
        if (e < 3 || e > BOUND16) begin
            errors++;
            $display("FAIL basic_latency: edge=%0d required 3..%0d", e, BOUND16);
        end
    endtask

    task automatic test_coprime;
        int e; bit s;
        logic [15:0] held;
        launch(1'b0, pack16(3571, 2711, 1543));
        wait_valid(1'b0, e, s);
        checks++;
        if (!s || d16 !== 16'd1 || e > BOUND16) begin
            errors++;
            $display("FAIL coprime_result: valid=%0b D=%0d edge=%0d required D=1 within %0d", s, d16, e, BOUND16);
        end
        held = d16;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (valid16 !== 1'b1 || d16 !== held || busy16 !== 1'b0) begin
                errors++;
                $display("FAIL coprime_hold: cycle=%0d valid=%0b D=%0d busy=%0b required valid=1 D=%0d busy=0",
                         i, valid16, d16, busy16, held);
            end
        end
    endtask

    task automatic test_zeros;
        logic [127:0] vec [3];
        logic [15:0]  exp [3];
        int e; bit s;
        vec[0] = pack16(0, 0, 12);  exp[0] = 16'd12;
        vec[1] = pack16(0, 0, 0);   exp[1] = 16'd0;
        vec[2] = pack16(48, 0, 36); exp[2] = 16'd12;
        for (int i = 0; i < 3; i++) begin
            launch(1'b0, vec[i]);
            wait_valid(1'b0, e, s);
            checks++;
            if (!s || d16 !== exp[i] || e < 3 || e > BOUND16) begin
                errors++;
                $display("FAIL zeros_%0d: valid=%0b D=%0d edge=%0d required D=%0d edge 3..%0d",
                         i, s, d16, e, exp[i], BOUND16);
            end
        end
    endtask

    task automatic test_random;
        int e; bit s;
        logic [127:0] o;
        longint unsigned exp;
        for (int r = 0; r < 10; r++) begin
            int f = $urandom_range(1, 200);
            o = pack16(16'(f * $urandom_range(0, 300)), 16'(f * $urandom_range(0, 300)),
                       16'(f * $urandom_range(0, 300)));
            if (r == 3) o = pack16(16'($urandom), 16'($urandom), 16'($urandom));
            exp = model(1'b0, o);
            launch(1'b0, o);
            wait_valid(1'b0, e, s);
            checks++;
            if (!s || longint'(d16) != exp || e < 3 || e > BOUND16) begin
                errors++;
                $display("FAIL random16_%0d: ops=%h valid=%0b D=%0d edge=%0d required D=%0d",
                         r, o[47:0], s, d16, e, exp);
            end
        end
        for (int r = 0; r < 6; r++) begin
            longint unsigned f = longint'($urandom_range(1, 4000));
            o = pack32(32'(f * $urandom_range(0, 1000000)), 32'(f * $urandom_range(0, 1000000)),
                       32'(f * $urandom_range(0, 1000000)), 32'(f * $urandom_range(0, 1000000)));
            exp = model(1'b1, o);
            launch(1'b1, o);
            wait_valid(1'b1, e, s);
            checks++;
            if (!s || longint'(d32) != exp || e < 3 || e > BOUND32) begin
                errors++;
                $display("FAIL random32_%0d: valid=%0b D=%0d edge=%0d required D=%0d", r, s, d32, e, exp);
            end
        end
    endtask

    task automatic test_restart;
        int rises;
        logic prev;
        int gap [3];
        gap[0] = 4; gap[1] = 0; gap[2] = 1;
        for (int t = 0; t < 3; t++) begin
            launch(1'b0, pack16(3571, 2711, 1543));
            repeat (gap[t]) @(negedge clk);
            launch(1'b0, pack16(48, 36, 60));
            rises = 0;
            prev  = valid16;
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                if (valid16 && !prev) rises++;
                prev = valid16;
            end
            checks++;
            if (rises != 1 || d16 !== 16'd12 || valid16 !== 1'b1) begin
                errors++;
                $display("FAIL restart_%0d: rises=%0d D=%0d valid=%0b required rises=1 D=12 valid=1",
                         t, rises, d16, valid16);
            end
        end
    endtask

    task automatic test_back_to_back;
        int e; bit s;
        // valid is high here; a new start must drop it on the capture edge
        launch(1'b0, pack16(90, 60, 45));
        checks++;
        if (valid16 !== 1'b0 || busy16 !== 1'b1) begin
            errors++;
            $display("FAIL start_on_valid: valid=%0b busy=%0b required valid=0 busy=1", valid16, busy16);
        end
        wait_valid(1'b0, e, s);
        checks++;
        if (!s || d16 !== 16'd15) begin
            errors++;
            $display("FAIL start_on_valid_result: valid=%0b D=%0d required D=15", s, d16);
        end
    endtask

    task automatic test_reset_mid;
        launch(1'b0, pack16(3571, 2711, 1543));
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy16 !== 1'b0 || valid16 !== 1'b0 || d16 !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%0b valid=%0b D=%0d required all 0", busy16, valid16, d16);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (valid16 !== 1'b0 || busy16 !== 1'b0) begin
                errors++;
                $display("FAIL reset_release: cycle=%0d valid=%0b busy=%0b required 0", c, valid16, busy16);
            end
        end
    endtask

    task automatic test_sweep;
        int e; bit s;
        launch(1'b1, pack32(32'hFFFFFFFE, 32'h80000000, 32'd6, 32'd10));
        wait_valid(1'b1, e, s);
        checks++;
        if (!s || d32 !== 32'd2 || e < 3 || e > BOUND32) begin
            errors++;
            $display("FAIL sweep32: valid=%0b D=%0d edge=%0d required D=2 edge 3..%0d", s, d32, e, BOUND32);
        end
        launch(1'b0, pack16(65535, 65535, 65535));
        wait_valid(1'b0, e, s);
        checks++;
        if (!s || d16 !== 16'd65535 || e < 3 || e > BOUND16) begin
            errors++;
            $display("FAIL sweep16_max: valid=%0b D=%0d edge=%0d required D=65535 edge 3..%0d",
                     s, d16, e, BOUND16);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_coprime();
        test_zeros();
        test_random();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
